dn_conv_acq: RTL and testbench

DN_CONV_ACQ -- requirements
Module: dn_conv_acq

---
 rtl/dn_conv_acq_pkg.sv | 39 +++
 rtl/dn_conv_acq_mixer.sv | 57 +++++
 rtl/dn_conv_acq.sv | 126 ++++++++++++
 tb/tb_dn_conv_acq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dn_conv_acq_pkg.sv
// Shared DSP package for the fs/4 down-converter with carrier phase acquisition.
// Holds the acquisition state encoding, the mixer idx-to-sign table and the
// default accumulation window.
package dn_conv_acq_pkg;

  localparam int WIN_LOG2_DEF = 8;
  localparam int SAMP_W       = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_LOCKED
  } acq_state_e;

  typedef enum logic [1:0] {
    SGN_ZERO,
    SGN_POS,
    SGN_NEG
  } mix_sgn_e;

  typedef struct packed {
    mix_sgn_e i_sgn;
    mix_sgn_e q_sgn;
  } mix_sgn_t;

  // fs/4 carrier: cos = [1,0,-1,0], -sin = [0,-1,0,1]
  function automatic mix_sgn_t mix_sgn(input logic [1:0] idx);
    mix_sgn_t s;
    case (idx)
      2'd0:    s = '{i_sgn: SGN_POS,  q_sgn: SGN_ZERO};
      2'd1:    s = '{i_sgn: SGN_ZERO, q_sgn: SGN_NEG};
      2'd2:    s = '{i_sgn: SGN_NEG,  q_sgn: SGN_ZERO};
      default: s = '{i_sgn: SGN_ZERO, q_sgn: SGN_POS};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dn_conv_acq_mixer.sv
// fs4_mixer: multiplies the input sample by the fs/4 I/Q carrier selected by
// idx and registers the result.
//   sys_clk, reset : clock, synchronous active-high reset
//   tp2            : signed input sample
//   idx            : carrier phase index (cnt + phase_sel)
//   i_mix          : unregistered I product (feeds the acquisition accumulator)
//   i_out, q_out   : registered I/Q products, 1-cycle latency
module fs4_mixer
  import dn_conv_acq_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic signed [SAMP_W-1:0] tp2,
  input  logic        [1:0]        idx,
  output logic signed [SAMP_W-1:0] i_mix,
  output logic signed [SAMP_W-1:0] i_out,
  output logic signed [SAMP_W-1:0] q_out
);

  localparam logic signed [SAMP_W-1:0] S_MIN = {1'b1, {(SAMP_W-1){1'b0}}};
  localparam logic signed [SAMP_W-1:0] S_MAX = {1'b0, {(SAMP_W-1){1'b1}}};

  logic signed [SAMP_W-1:0] neg;
  logic signed [SAMP_W-1:0] q_mix;
  mix_sgn_t                 sg;

  function automatic logic signed [SAMP_W-1:0] apply_sgn(
    input mix_sgn_e                 s,
    input logic signed [SAMP_W-1:0] p,
    input logic signed [SAMP_W-1:0] n
  );
    case (s)
      SGN_POS: return p;
      SGN_NEG: return n;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    sg    = mix_sgn(idx);
    // -(-2^17) is not representable; clamp to the positive full scale
    neg   = (tp2 == S_MIN) ? S_MAX : -tp2;
    i_mix = apply_sgn(sg.i_sgn, tp2, neg);
    q_mix = apply_sgn(sg.q_sgn, tp2, neg);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      i_out <= '0;
      q_out <= '0;
    end else begin
      i_out <= i_mix;
      q_out <= q_mix;
    end
  end

endmodule

// File: rtl/dn_conv_acq.sv
// dn_conv_acq: fs/4 down-converter with carrier phase acquisition.
// On start it accumulates the I product for 2^WIN_LOG2 samples under each of
// the four carrier phase offsets, then locks onto the offset with the largest
// signed sum (ties -> lowest offset).
//   sys_clk, reset        : clock, synchronous active-high reset
//   tp2                   : signed fs/4-upconverted input sample
//   start                 : 1-cycle acquisition request (ignored while busy)
//   I_out, Q_out          : registered mixer outputs
//   output_to_DAC_I/Q     : offset-binary 14-bit versions of I_out/Q_out
//   phase_sel             : carrier phase offset in use
//   busy, locked          : acquisition running / acquisition complete
module dn_conv_acq
  import dn_conv_acq_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic signed [SAMP_W-1:0] tp2,
  input  logic                     start,
  output logic signed [SAMP_W-1:0] I_out,
  output logic signed [SAMP_W-1:0] Q_out,
  output logic        [13:0]       output_to_DAC_I,
  output logic        [13:0]       output_to_DAC_Q,
  output logic        [1:0]        phase_sel,
  output logic                     busy,
  output logic                     locked
);

  // one sign bit of headroom per window doubling plus one for the +/-2^17 range
  localparam int ACC_W = SAMP_W + 1 + WIN_LOG2;

  acq_state_e               state_q, state_d;
  logic [1:0]               cnt, idx;
  logic [1:0]               trial_q, trial_d, ps_d, best;
  logic [WIN_LOG2-1:0]      sc_q, sc_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic signed [ACC_W-1:0]  sums_q [4];
  logic signed [ACC_W-1:0]  sums_d [4];
  logic signed [SAMP_W-1:0] i_mix;

  assign idx = cnt + phase_sel;

  fs4_mixer u_mix (
    .sys_clk (sys_clk),
    .reset   (reset),
    .tp2     (tp2),
    .idx     (idx),
    .i_mix   (i_mix),
    .i_out   (I_out),
    .q_out   (Q_out)
  );

  assign output_to_DAC_I = {~I_out[17], I_out[16:4]};
  assign output_to_DAC_Q = {~Q_out[17], Q_out[16:4]};
  assign busy            = (state_q == ST_MEASURE) || (state_q == ST_COMPARE);
  assign locked          = (state_q == ST_LOCKED);

  assign acc_sum = acc_q + ACC_W'(i_mix);

  // strict '>' keeps the lowest index on ties
  always_comb begin
    best = 2'd0;
    for (int j = 1; j < 4; j++)
      if (sums_q[j] > sums_q[best]) best = 2'(j);
  end

  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    ps_d    = phase_sel;
    sc_d    = sc_q;
    acc_d   = acc_q;
    sums_d  = sums_q;
    case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (start) begin
          state_d = ST_MEASURE;
          trial_d = 2'd0;
          ps_d    = 2'd0;
          sc_d    = '0;
          acc_d   = '0;
        end
      end
      ST_MEASURE: begin
        sc_d = sc_q + 1'b1;
        if (sc_q == '1) begin
          // last sample of the window goes straight into the stored sum
          sums_d[trial_q] = acc_sum;
          acc_d           = '0;
          trial_d         = trial_q + 2'd1;
          ps_d            = trial_q + 2'd1;
          if (trial_q == 2'd3) state_d = ST_COMPARE;
        end else begin
          acc_d = acc_sum;
        end
      end
      ST_COMPARE: begin
        ps_d    = best;
        state_d = ST_LOCKED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt       <= 2'd0;
      trial_q   <= 2'd0;
      phase_sel <= 2'd0;
      sc_q      <= '0;
      acc_q     <= '0;
      for (int j = 0; j < 4; j++) sums_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      cnt       <= cnt + 2'd1;
      trial_q   <= trial_d;
      phase_sel <= ps_d;
      sc_q      <= sc_d;
      acc_q     <= acc_d;
      for (int j = 0; j < 4; j++) sums_q[j] <= sums_d[j];
    end
  end

endmodule

// File: tb/tb_dn_conv_acq.sv
// Self-checking bench for dn_conv_acq (WIN_LOG2 = 4). Expected values come
// from an arithmetic model of the fs/4 carrier and per-trial sums.
module tb_dn_conv_acq;

  localparam int WL = 4;
  localparam int N  = 1 << WL;

  logic               sys_clk = 1'b0;
  logic               reset   = 1'b1;
  logic               start   = 1'b0;
  logic signed [17:0] tp2     = '0;
  logic signed [17:0] I_out, Q_out;
  logic        [13:0] dac_i, dac_q;
  logic        [1:0]  phase_sel;
  logic               busy, locked;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;   // cycles since reset release; cnt == cyc mod 4
  int exp_ps = 0;

  dn_conv_acq #(.WIN_LOG2(WL)) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .tp2             (tp2),
    .start           (start),
    .I_out           (I_out),
    .Q_out           (Q_out),
    .output_to_DAC_I (dac_i),
    .output_to_DAC_Q (dac_q),
    .phase_sel       (phase_sel),
    .busy            (busy),
    .locked          (locked)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int clamp(input int v);
    return (v > 131071) ? 131071 : v;
  endfunction

  function automatic int ref_i(input int idx, input int x);
    int c [4];
    c = '{1, 0, -1, 0};
    return clamp(c[idx % 4] * x);
  endfunction

  function automatic int ref_q(input int idx, input int x);
    int s [4];
    s = '{0, -1, 0, 1};
    return clamp(s[idx % 4] * x);
  endfunction

  function automatic int dac_of(input int v);
    return (v + 131072) >> 4;
  endfunction

  function automatic int rnd_samp();
    return int'($urandom_range(262143)) - 131072;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tp2   = 18'sd5000;
    repeat (3) tick();
    total++; if (I_out !== 18'sd0) begin bad++; $display("FAIL reset I_out: got %0d want 0", I_out); end
    total++; if (Q_out !== 18'sd0) begin bad++; $display("FAIL reset Q_out: got %0d want 0", Q_out); end
    total++; if (dac_i !== 14'h2000) begin bad++; $display("FAIL reset dac_i: got %h want 2000", dac_i); end
    total++; if (dac_q !== 14'h2000) begin bad++; $display("FAIL reset dac_q: got %h want 2000", dac_q); end
    total++; if (phase_sel !== 2'd0) begin bad++; $display("FAIL reset phase_sel: got %0d want 0", phase_sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset locked: got %b want 0", locked); end
    reset  = 1'b0;
    cyc    = 0;
    exp_ps = 0;
  endtask

  // Mixer check in IDLE/LOCKED: constant val, or random samples when rnd=1
  task automatic test_mixing(input int val, input int cycles, input bit rnd);
    int x, ei, eq;
    for (int k = 0; k < cycles; k++) begin
      x   = rnd ? rnd_samp() : val;
      tp2 = 18'(x);
      ei  = ref_i(cyc + exp_ps, x);
      eq  = ref_q(cyc + exp_ps, x);
      tick();
      total++; if (I_out !== 18'(ei)) begin bad++; $display("FAIL mix I_out cyc%0d: got %0d want %0d", cyc, I_out, ei); end
      total++; if (Q_out !== 18'(eq)) begin bad++; $display("FAIL mix Q_out cyc%0d: got %0d want %0d", cyc, Q_out, eq); end
      total++; if (dac_i !== 14'(dac_of(ei))) begin bad++; $display("FAIL mix dac_i: got %h want %h", dac_i, 14'(dac_of(ei))); end
      total++; if (dac_q !== 14'(dac_of(eq))) begin bad++; $display("FAIL mix dac_q: got %h want %h", dac_q, 14'(dac_of(eq))); end
      total++; if (phase_sel !== 2'(exp_ps)) begin bad++; $display("FAIL hold phase_sel: got %0d want %0d", phase_sel, exp_ps); end
    end
  endtask

  // mode 0: 1000*c((t+1)%4); 1: random-phase carrier + noise; 2: -131072;
  // 3: zero; 4: full-range random. restart_at: MEASURE cycle to re-pulse start.
  task automatic acquire(input int mode, input int restart_at);
    longint s [4];
    int     c [4];
    int     amp, ph, x, best;
    c   = '{1, 0, -1, 0};
    amp = int'($urandom_range(20000, 500));
    ph  = int'($urandom_range(3));
    for (int j = 0; j < 4; j++) s[j] = 0;
    start = 1'b1;
    tp2   = 18'sd0;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL start taken: busy=%b locked=%b want 1/0", busy, locked); end
    for (int k = 0; k < 4 * N; k++) begin
      case (mode)
        0:       x = 1000 * c[(cyc + 1) % 4];
        1:       x = amp * c[(cyc + ph) % 4] + int'($urandom_range(400)) - 200;
        2:       x = -131072;
        3:       x = 0;
        default: x = rnd_samp();
      endcase
      tp2 = 18'(x);
      s[k / N] += longint'(ref_i(cyc + k / N, x));
      if (k == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      total++; if (busy !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL acq timing k=%0d: busy=%b locked=%b want 1/0", k, busy, locked); end
    end
    best = 0;
    for (int j = 1; j < 4; j++) if (s[j] > s[best]) best = j;
    tick();
    total++; if (locked !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL acq lock at 4N+2: busy=%b locked=%b want 0/1", busy, locked); end
    total++; if (phase_sel !== 2'(best)) begin bad++; $display("FAIL acq phase_sel mode%0d: got %0d want %0d", mode, phase_sel, best); end
    exp_ps = best;
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2 * N + 5; k++) begin
      tp2 = 18'(rnd_samp());
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    total++; if (phase_sel !== 2'd0) begin bad++; $display("FAIL midrst phase_sel: got %0d want 0", phase_sel); end
    total++; if (busy !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL midrst busy/locked: got %b/%b want 0/0", busy, locked); end
    total++; if (I_out !== 18'sd0) begin bad++; $display("FAIL midrst I_out: got %0d want 0", I_out); end
    reset  = 1'b0;
    cyc    = 0;
    exp_ps = 0;
    acquire(0, -1);
  endtask

  initial begin
    test_reset();
    test_mixing(1000, 8, 1'b0);
    test_mixing(-131072, 4, 1'b0);
    test_mixing(0, 12, 1'b1);
    acquire(0, -1);                  // basic acquisition, start from IDLE
    test_mixing(0, 8, 1'b1);         // LOCKED: hold and mix with winner
    acquire(3, -1);                  // all-zero tie, start while LOCKED
    acquire(1, N + 3);               // start re-pulsed mid-MEASURE
    acquire(2, -1);                  // saturating input, tie
    acquire(1, -1);
    acquire(4, 2 * N);
    acquire(4, -1);
    test_mixing(0, 8, 1'b1);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
